// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and issues in-order imem requests.
// Returned words are buffered in a small queue whose head feeds IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        instr_valid
);
  localparam int          PW = $clog2(QDEPTH);
  localparam int          CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]              state;
  logic [31:0]             pc, resp_pc, tgt_pc;
  logic [CW-1:0]           occ, out_cnt, drop_cnt, drop_nxt;
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [QDEPTH-1:0][31:0] q_instr, q_tag;
  logic                    fire, push, pop;
  logic [CW:0]             credit;
  logic                    unused;

  assign unused = ^redirect_pc[1:0];
  assign tgt_pc = {redirect_pc[31:2], 2'b00};

  assign instr_valid  = (occ != '0);
  assign instr_out    = instr_valid ? q_instr[rd_ptr] : 32'h0;
  assign pc_plus4_out = instr_valid ? q_tag[rd_ptr]   : 32'h0;

  assign pop  = instr_valid && !stall && !redirect;
  assign push = (state == FETCH) && (drop_cnt == '0) && imem_rvalid && !redirect;

  // A head leaving this cycle frees its slot before any new response can
  // land, so counting it keeps single-cycle memory at one instr per cycle.
  assign credit   = {1'b0, occ} + {1'b0, out_cnt} - {{CW{1'b0}}, pop};
  assign imem_req = !rst && (state == FETCH) && !redirect && (credit < QD);
  assign imem_addr = pc;
  assign fire     = imem_req && imem_gnt;

  // Requests still in flight after a redirect edge in FETCH.
  assign drop_nxt = out_cnt + CW'(fire) - CW'(imem_rvalid && state == FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      occ      <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      pc      <= tgt_pc;
      resp_pc <= tgt_pc;
      occ     <= '0;
      out_cnt <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      if (state == FETCH) begin
        drop_cnt <= drop_nxt;
        state    <= (drop_nxt != '0) ? DRAIN : FETCH;
      end else begin
        drop_cnt <= drop_cnt - CW'(imem_rvalid);
        if (imem_rvalid && drop_cnt == CW'(1)) state <= FETCH;
      end
    end else begin
      if (fire) pc <= pc + 32'd4;
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      occ     <= occ + CW'(push) - CW'(pop);
      out_cnt <= out_cnt + CW'(fire) - CW'(push);
      if (state == DRAIN && imem_rvalid) begin
        drop_cnt <= drop_cnt - CW'(1);
        if (drop_cnt == CW'(1)) state <= FETCH;
      end
    end
  end

  // Responses arrive in request order within a path, so each tag is simply
  // the next sequential PC+4 after the last accepted word.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_tag[wr_ptr]   <= resp_pc + 32'd4;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a stream-level model:
// each path must deliver consecutive words from its target, none from stale paths.
module tb_fetch_unit;
  logic        clk, rst, stall, redirect, imem_req, imem_gnt, imem_rvalid, instr_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr_out, pc_plus4_out;

  fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .pc_plus4_out(pc_plus4_out), .instr_valid(instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
  req_t        pend[$];
  int          cyc, lat, epoch, nchecks, nerr;
  bit          lat_rand, redir_prev;
  logic [31:0] exp_issue, exp_pop;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc4, h_i, h_p, g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample, check, update model.
  task automatic tick();
    int   stale;
    bit   rv;
    req_t r;
    rv = 1'b0;
    if (pend.size() > 0) rv = (pend[0].due <= cyc);
    imem_rvalid = rv;
    if (rv) imem_rdata = pend[0].addr ^ 32'hA5A5_0000;
    else    imem_rdata = $urandom;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_instr = instr_out; s_pc4 = pc_plus4_out;
    stale = 0;
    foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
    if (imem_req) chk("issue_addr", imem_addr, exp_issue);
    if (redirect || stale > 0) chk_b("no_req_drain_or_redirect", imem_req, 1'b0);
    if (redir_prev) chk_b("valid_after_redirect", instr_valid, 1'b0);
    if (instr_valid) begin
      chk("head_instr", instr_out, exp_pop ^ 32'hA5A5_0000);
      chk("head_pc4", pc_plus4_out, exp_pop + 32'd4);
    end else begin
      chk("nop_instr", instr_out, 32'h0);
      chk("nop_pc4", pc_plus4_out, 32'h0);
    end
    if (instr_valid && !stall && !redirect) exp_pop += 32'd4;
    if (rv) void'(pend.pop_front());
    if (imem_req && imem_gnt) begin
      r.addr  = imem_addr;
      r.due   = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat);
      r.epoch = epoch;
      pend.push_back(r);
      exp_issue += 32'd4;
    end
    redir_prev = redirect;
    if (redirect) begin
      epoch++;
      exp_issue = {redirect_pc[31:2], 2'b00};
      exp_pop   = exp_issue;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #1;
    chk_b("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc4", pc_plus4_out, 32'h0);
    chk_b("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    cyc = 0; epoch = 0; exp_issue = 32'h0; exp_pop = 32'h0; redir_prev = 1'b0;
  endtask

  initial begin
    nchecks = 0; nerr = 0; lat = 1; lat_rand = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Single-cycle memory, streaming from reset
    do_reset(); imem_gnt = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_b("A_valid_stream", s_valid, k >= 2);
      if (k == 0) chk("A_first_addr", s_addr, 32'h0);
      if (k == 2) chk("A_first_pc4", s_pc4, 32'h4);
    end

    // Stall with a full queue
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_b("B_req_in_stall", s_req, 1'b0);
      chk_b("B_valid_in_stall", s_valid, 1'b1);
      if (k == 0) begin h_i = s_instr; h_p = s_pc4; end
      else begin
        chk("B_hold_instr", s_instr, h_i);
        chk("B_hold_pc4", s_pc4, h_p);
      end
    end
    stall = 1'b0;
    repeat (8) tick();

    // 3-cycle memory, redirect with two requests in flight
    do_reset(); lat = 3; imem_gnt = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103; tick(); redirect = 1'b0;
    tick(); chk_b("D_drain_c3", s_req, 1'b0);
    tick(); chk_b("D_drain_c4", s_req, 1'b0);
    tick(); chk_b("D_req_c5", s_req, 1'b1); chk("D_addr_c5", s_addr, 32'h0000_0100);
    tick(); tick(); tick(); chk_b("D_valid_c8", s_valid, 1'b0);
    tick(); chk_b("D_valid_c9", s_valid, 1'b1); chk("D_pc4_c9", s_pc4, 32'h0000_0104);

    // Redirect in the same cycle as a response and a raised grant
    do_reset(); lat = 2; imem_gnt = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0300; tick(); redirect = 1'b0;
    tick(); chk_b("E_drain_c3", s_req, 1'b0); chk_b("E_valid_c3", s_valid, 1'b0);
    tick(); chk_b("E_req_c4", s_req, 1'b1); chk("E_addr_c4", s_addr, 32'h0000_0300);
    chk_b("E_valid_c4", s_valid, 1'b0);
    repeat (6) tick();

    // Grant held low for four cycles
    do_reset(); lat = 1; imem_gnt = 1'b1;
    repeat (6) tick();
    imem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_b("F_req_held", s_req, 1'b1);
      if (k == 0) g = s_addr;
      else chk("F_addr_stable", s_addr, g);
      if (k >= 2) begin
        chk_b("F_bubble_valid", s_valid, 1'b0);
        chk("F_bubble_instr", s_instr, 32'h0);
        chk("F_bubble_pc4", s_pc4, 32'h0);
      end
    end
    imem_gnt = 1'b1;
    repeat (6) tick();

    // PC wrap, then async reset while draining
    do_reset(); lat = 1; imem_gnt = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect = 1'b0;
    tick(); chk_b("G_req_c2", s_req, 1'b1); chk("G_addr_c2", s_addr, 32'hFFFF_FFFC);
    tick(); chk_b("G_req_c3", s_req, 1'b1); chk("G_wrap_addr", s_addr, 32'h0);
    lat = 3;
    tick(); chk_b("G_valid_c4", s_valid, 1'b1); chk("G_wrap_tag", s_pc4, 32'h0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0040; tick(); redirect = 1'b0;
    tick(); chk_b("G_drain_c7", s_req, 1'b0);
    do_reset();

    // Randomized traffic: stalls, grant gaps, variable latency, redirects
    lat_rand = 1'b1;
    for (int k = 0; k < 400; k++) begin
      stall       = ($urandom_range(0, 99) < 30);
      imem_gnt    = ($urandom_range(0, 99) < 70);
      redirect    = ($urandom_range(0, 99) < 5);
      redirect_pc = $urandom;
      tick();
    end
    redirect = 1'b0; stall = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
